// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor.
//   state_t       : FSM encoding (ST_IDLE, ST_RUN)
//   DEFAULT_WIDTH : default operand/result width
package serial_subtractor_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: diff = a - b - borrow.
// Ports:
//   a_in, b_in  : operand bits (minuend, subtrahend)
//   borrow_in   : incoming borrow
//   diff_out    : difference bit
//   borrow_out  : outgoing borrow
module full_subtractor (
  input  logic a_in,
  input  logic b_in,
  input  logic borrow_in,
  output logic diff_out,
  output logic borrow_out
);

  assign diff_out   = a_in ^ b_in ^ borrow_in;
  // Borrow out when b exceeds a, or when they tie and a borrow is pending.
  assign borrow_out = (~a_in & b_in) | (~(a_in ^ b_in) & borrow_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = (a - b - borrow_in) mod 2^WIDTH,
// one bit per clock, LSB first, with a registered borrow.
// Ports:
//   clk_in, reset_in    : clock, synchronous active-high reset
//   start_in            : request, accepted only while idle
//   a_in, b_in          : operands, captured on the accepting edge
//   borrow_in           : initial borrow, captured on the accepting edge
//   busy_out            : operation in progress
//   done_out            : one-cycle pulse, new result valid
//   diff_out            : result, held until the next completion
//   borrow_out          : final borrow (a < b + borrow_in), held like diff_out
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             borrow_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             br;
  logic [CNT_W-1:0] count;

  logic cell_diff;
  logic cell_borrow;

  full_subtractor u_cell (
    .a_in      (a_sh[0]),
    .b_in      (b_sh[0]),
    .borrow_in (br),
    .diff_out  (cell_diff),
    .borrow_out(cell_borrow)
  );

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state      <= ST_IDLE;
      busy_out   <= 1'b0;
      done_out   <= 1'b0;
      diff_out   <= '0;
      borrow_out <= 1'b0;
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      br         <= 1'b0;
      count      <= '0;
    end else begin
      done_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_in) begin
            a_sh     <= a_in;
            b_sh     <= b_in;
            br       <= borrow_in;
            count    <= '0;
            busy_out <= 1'b1;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          br     <= cell_borrow;
          // Result bits enter at the MSB so the LSB ends up at bit 0.
          res_sh <= {cell_diff, res_sh[WIDTH-1:1]};
          count  <= count + 1'b1;
          if (count == LAST) begin
            diff_out   <= {cell_diff, res_sh[WIDTH-1:1]};
            borrow_out <= cell_borrow;
            done_out   <= 1'b1;
            busy_out   <= 1'b0;
            state      <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor, the inverse of the team's full_adder arithmetic path. It computes diff = a - b - borrow_in by running one full-subtractor cell LSB-first, one bit per clock, with a registered borrow. A start/busy/done handshake lets a stimulus FSM or datapath issue operands and collect the result together with a final borrow.

Parameters:
WIDTH, 8, operand and result width in bits (WIDTH >= 2)
CNT_W, $clog2(WIDTH)+1, bit-counter width (derived; do not override)

Ports:
clk_in  input  1  single system clock; all state changes on its rising edge
reset_in  input  1  synchronous, active-high reset
start_in  input  1  request; sampled only while idle (busy_out=0)
a_in  input  WIDTH  minuend; sampled on the accepting edge only
b_in  input  WIDTH  subtrahend; sampled on the accepting edge only
borrow_in  input  1  initial borrow; sampled on the accepting edge only
busy_out  output  1  high while an operation is in progress
done_out  output  1  one-cycle pulse marking a new valid result
diff_out  output  WIDTH  result; holds its value until the next completion
borrow_out  output  1  final borrow (1 when a < b + borrow_in, unsigned); held like diff_out

Behaviour:
- Reset (synchronous, active-high): on a clk_in edge with reset_in=1, state=IDLE and busy_out=0, done_out=0, diff_out=0, borrow_out=0. Internal operand, borrow and counter registers are cleared. Reset overrides start_in.
- FSM states: IDLE and RUN.
- IDLE -> RUN at edge E0 when start_in=1:
  - latch a_in and b_in into shift registers;
  - borrow flop <= borrow_in; count <= 0; busy_out <= 1.
- RUN, edges E1..E_WIDTH: edge Ek processes bit k-1.
  - d = a ^ b ^ br
  - br_next = (~a & b) | (~(a ^ b) & br)
  - d shifts into the result shift register from the MSB end; operand registers shift right; count increments.
- At E_WIDTH (count == WIDTH-1):
  - diff_out <= completed result; borrow_out <= br_next;
  - done_out <= 1; busy_out <= 0; state -> IDLE.
- Latency: done_out is high in the cycle following E_WIDTH, exactly WIDTH cycles after the accepting edge. Throughput is one operation per WIDTH+1 cycles at best.
- done_out is high for exactly one cycle, then 0.
- start_in while busy_out=1 is ignored. There is no queueing and no error flag.
- start_in during the done_out cycle is accepted, because the FSM is already IDLE. done_out drops on that edge, and diff_out/borrow_out keep the previous result until the new completion.
- Input changes on a_in/b_in/borrow_in during RUN have no effect.
- Reset mid-RUN aborts the operation: no done_out pulse, and outputs are cleared as above.
- Arithmetic: unsigned modulo 2^WIDTH. diff_out = (a - b - borrow_in) mod 2^WIDTH, and borrow_out = 1 iff a < b + borrow_in.

Decomposition:
- Shared constants file: state encodings (ST_IDLE=1'b0, ST_RUN=1'b1) and the default WIDTH.
- One combinational sub-module, full_subtractor (ports a_in, b_in, borrow_in, diff_out, borrow_out). It is the single bit cell instantiated by serial_subtractor and is unit-testable exhaustively (8 vectors).

Test Plan:
- WIDTH=8, a=0x5A, b=0x23, borrow_in=0, start pulsed at E0 -> done_out high in the cycle after E8 only; diff_out=0x37, borrow_out=0; busy_out high E0..E8.
- a=0x00, b=0x01, borrow_in=0 -> diff_out=0xFF, borrow_out=1. Then a=0x10, b=0x10, borrow_in=1 -> diff_out=0xFF, borrow_out=1.
- start_in held high through a run with a/b changed mid-run -> exactly one result (first operands). The next operation is accepted on the done_out cycle; results appear back-to-back every 9 cycles.
- Reset asserted at E4 of a run (a=0xF0, b=0x0F) -> busy_out=0, diff_out=0, borrow_out=0 the next cycle, no done_out pulse. A subsequent start completes normally (0xE1, borrow 0).
- WIDTH=4 exhaustive: all 16x16x2 (a, b, borrow_in) combinations, one per operation -> diff_out and borrow_out match (a-b-borrow_in) mod 16 and a<b+borrow_in; done_out count equals 512.
